vga_console_ctrl: RTL

Text-console sequencer that sits in front of the VGA character controller as a second bus master. It accepts one character byte per handshake, tracks the cursor, and issues the system-bus writes that update the character map and colour map. It handles CR, LF, backspace and form-feed, and clears a fresh row on line advance so the CPU can print without computing addresses.

---
 rtl/vga_console_ctrl_if.sv | 35 +++
 rtl/vga_console_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_console_ctrl_if.sv
// rtl/vga_console_ctrl_if.sv - character handshake, status and bus-write signals of the console sequencer
// Purpose: groups every non-clock signal of vga_console_ctrl.
// Signals:
//   char_i, color_i, char_valid_i -> char_ready_o      character handshake
//   busy_o, cursor_x_o, cursor_y_o                     sequencer status
//   req_o, write_enable_o, mem_be_o, addr_o,
//   write_data_o -> gnt_i                              system-bus write port
// Modports: master = sequencer side, slave = CPU/bus side.
interface vga_console_ctrl_if;
   logic [7:0]  char_i;
   logic [7:0]  color_i;
   logic        char_valid_i;
   logic        char_ready_o;
   logic        busy_o;
   logic [6:0]  cursor_x_o;
   logic [4:0]  cursor_y_o;
   logic        req_o;
   logic        write_enable_o;
   logic [3:0]  mem_be_o;
   logic [31:0] addr_o;
   logic [31:0] write_data_o;
   logic        gnt_i;

   modport master (
      input  char_i, color_i, char_valid_i, gnt_i,
      output char_ready_o, busy_o, cursor_x_o, cursor_y_o,
             req_o, write_enable_o, mem_be_o, addr_o, write_data_o
   );

   modport slave (
      output char_i, color_i, char_valid_i, gnt_i,
      input  char_ready_o, busy_o, cursor_x_o, cursor_y_o,
             req_o, write_enable_o, mem_be_o, addr_o, write_data_o
   );
endinterface

// File: rtl/vga_console_ctrl.sv
// rtl/vga_console_ctrl.sv - text-console sequencer issuing character/colour map writes
// Purpose: accepts one character per handshake, tracks the cursor, handles CR/LF/BS/FF
//          and clears a fresh row (or the whole screen) through registered bus writes.
// Ports:
//   clk_i  system clock
//   rst_i  synchronous active-high reset
//   bus    vga_console_ctrl_if.master: character handshake, status, bus write port
module vga_console_ctrl #(
   parameter int          COLS      = 80,
   parameter int          ROWS      = 30,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic               clk_i,
   input  logic               rst_i,
   vga_console_ctrl_if.master bus
);
   localparam logic [31:0] COLOR_OFS = 32'h0000_1000;
   localparam logic [9:0]  ROW_WORDS = 10'(COLS / 4);
   localparam logic [9:0]  LAST_WORD = 10'(ROWS * COLS / 4 - 1);
   localparam logic [6:0]  LAST_COL  = 7'(COLS - 1);
   localparam logic [4:0]  LAST_ROW  = 5'(ROWS - 1);

   typedef enum logic [2:0] {
      ST_IDLE, ST_WR_CHAR, ST_WR_COL, ST_CLR_CHAR, ST_CLR_COL
   } state_t;

   state_t      r_state, w_state_nxt;
   logic [6:0]  r_x, w_x_nxt;
   logic [4:0]  r_y, w_y_nxt;
   logic [7:0]  r_color, w_color_nxt;
   logic [11:0] r_off, w_off_nxt;
   logic        r_bs, w_bs_nxt;
   logic [9:0]  r_word, w_word_nxt;
   logic [9:0]  r_word_last, w_word_last_nxt;
   logic        r_req, w_req_nxt;
   logic [3:0]  r_be, w_be_nxt;
   logic [31:0] r_addr, w_addr_nxt;
   logic [31:0] r_data, w_data_nxt;

   logic        w_accept;
   logic [11:0] w_off_cur, w_off_prev;
   logic [4:0]  w_y_inc;
   logic [9:0]  w_row_first, w_word_inc;
   logic        w_start_wr, w_start_clr;
   logic [11:0] w_wr_off;
   logic [7:0]  w_wr_byte;
   logic [9:0]  w_clr_first, w_clr_last;

   function automatic logic [31:0] f_addr(input logic [9:0] word, input logic color_map);
      return BASE_ADDR + (color_map ? COLOR_OFS : 32'd0) + {20'd0, word, 2'b00};
   endfunction

   assign bus.char_ready_o   = (r_state == ST_IDLE) & ~rst_i;
   assign bus.busy_o         = (r_state != ST_IDLE);
   assign bus.cursor_x_o     = r_x;
   assign bus.cursor_y_o     = r_y;
   assign bus.req_o          = r_req;
   assign bus.write_enable_o = r_req;
   assign bus.mem_be_o       = r_be;
   assign bus.addr_o         = r_addr;
   assign bus.write_data_o   = r_data;

   assign w_accept    = bus.char_valid_i & bus.char_ready_o;
   assign w_off_cur   = 12'(r_y) * 12'(COLS) + 12'(r_x);
   assign w_off_prev  = w_off_cur - 12'd1;
   assign w_y_inc     = (r_y == LAST_ROW) ? 5'd0 : r_y + 5'd1;
   // Row clears always target the row the cursor is moving onto.
   assign w_row_first = 10'(w_y_inc) * ROW_WORDS;
   assign w_word_inc  = r_word + 10'd1;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state     <= ST_IDLE;
         r_x         <= '0;
         r_y         <= '0;
         r_color     <= '0;
         r_off       <= '0;
         r_bs        <= 1'b0;
         r_word      <= '0;
         r_word_last <= '0;
         r_req       <= 1'b0;
         r_be        <= '0;
         r_addr      <= '0;
         r_data      <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_x         <= w_x_nxt;
         r_y         <= w_y_nxt;
         r_color     <= w_color_nxt;
         r_off       <= w_off_nxt;
         r_bs        <= w_bs_nxt;
         r_word      <= w_word_nxt;
         r_word_last <= w_word_last_nxt;
         r_req       <= w_req_nxt;
         r_be        <= w_be_nxt;
         r_addr      <= w_addr_nxt;
         r_data      <= w_data_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_x_nxt         = r_x;
      w_y_nxt         = r_y;
      w_color_nxt     = r_color;
      w_off_nxt       = r_off;
      w_bs_nxt        = r_bs;
      w_word_nxt      = r_word;
      w_word_last_nxt = r_word_last;
      w_req_nxt       = r_req;
      w_be_nxt        = r_be;
      w_addr_nxt      = r_addr;
      w_data_nxt      = r_data;
      w_start_wr      = 1'b0;
      w_wr_off        = w_off_cur;
      w_wr_byte       = bus.char_i;
      w_start_clr     = 1'b0;
      w_clr_first     = w_row_first;
      w_clr_last      = w_row_first + ROW_WORDS - 10'd1;

      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               w_color_nxt = bus.color_i;
               if (bus.char_i >= 8'h20) begin
                  w_bs_nxt   = 1'b0;
                  w_start_wr = 1'b1;
               end else begin
                  case (bus.char_i)
                     8'h0D: w_x_nxt = '0;
                     8'h0A: begin
                        w_x_nxt     = '0;
                        w_y_nxt     = w_y_inc;
                        w_start_clr = 1'b1;
                     end
                     8'h08: begin
                        // The cursor itself moves back only on the colour-write grant.
                        if (r_x != 7'd0) begin
                           w_bs_nxt   = 1'b1;
                           w_wr_off   = w_off_prev;
                           w_wr_byte  = 8'h20;
                           w_start_wr = 1'b1;
                        end
                     end
                     8'h0C: begin
                        w_x_nxt     = '0;
                        w_y_nxt     = '0;
                        w_clr_first = '0;
                        w_clr_last  = LAST_WORD;
                        w_start_clr = 1'b1;
                     end
                     default: ;
                  endcase
               end
            end
         end
         ST_WR_CHAR: begin
            if (bus.gnt_i) begin
               w_state_nxt = ST_WR_COL;
               w_addr_nxt  = f_addr(r_off[11:2], 1'b1);
               w_data_nxt  = {4{r_color}};
            end
         end
         ST_WR_COL: begin
            if (bus.gnt_i) begin
               w_state_nxt = ST_IDLE;
               w_req_nxt   = 1'b0;
               if (r_bs) begin
                  w_x_nxt = r_x - 7'd1;
               end else if (r_x == LAST_COL) begin
                  w_x_nxt     = '0;
                  w_y_nxt     = w_y_inc;
                  w_start_clr = 1'b1;
               end else begin
                  w_x_nxt = r_x + 7'd1;
               end
            end
         end
         ST_CLR_CHAR: begin
            if (bus.gnt_i) begin
               w_state_nxt = ST_CLR_COL;
               w_addr_nxt  = f_addr(r_word, 1'b1);
               w_data_nxt  = {4{r_color}};
            end
         end
         ST_CLR_COL: begin
            if (bus.gnt_i) begin
               if (r_word == r_word_last) begin
                  w_state_nxt = ST_IDLE;
                  w_req_nxt   = 1'b0;
               end else begin
                  w_state_nxt = ST_CLR_CHAR;
                  w_word_nxt  = w_word_inc;
                  w_addr_nxt  = f_addr(w_word_inc, 1'b0);
                  w_data_nxt  = 32'h2020_2020;
               end
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase

      // The first write of a sequence is loaded here so it is presented the cycle after entry.
      if (w_start_wr) begin
         w_state_nxt = ST_WR_CHAR;
         w_off_nxt   = w_wr_off;
         w_req_nxt   = 1'b1;
         w_be_nxt    = 4'b0001 << w_wr_off[1:0];
         w_addr_nxt  = f_addr(w_wr_off[11:2], 1'b0);
         w_data_nxt  = {4{w_wr_byte}};
      end
      if (w_start_clr) begin
         w_state_nxt     = ST_CLR_CHAR;
         w_word_nxt      = w_clr_first;
         w_word_last_nxt = w_clr_last;
         w_req_nxt       = 1'b1;
         w_be_nxt        = 4'b1111;
         w_addr_nxt      = f_addr(w_clr_first, 1'b0);
         w_data_nxt      = 32'h2020_2020;
      end
   end
endmodule
